ramb16_s9_s9: RTL and testbench
===============================

RAMB16_S9_S9 -- requirements
Module: ramb16_s9_s9

Interface
REQ-001 Parameter WRITE_MODE_A, default "WRITE_FIRST"; port A output on write: "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
REQ-002 Parameter WRITE_MODE_B, default "WRITE_FIRST"; same choices for port B.
REQ-003 Parameter SIM_COLLISION_CHECK, default "ALL"; collision reporting: "NONE", "WARNING_ONLY", "GENERATE_X_ONLY" or "ALL".
REQ-004 Parameters INIT_A and INIT_B, 9-bit, default 0; output register value after reset.
REQ-005 Parameters SRVAL_A and SRVAL_B, 9-bit, default 0; output register value on synchronous set/reset.
REQ-006 The block SHALL have one clock and asynchronous active-high reset; port "clock" input 1, the single clock for both ports.
REQ-007 Port "reset" input 1, asynchronous active-high, clears the output registers only.
REQ-008 WEA/WEB input 1, port write enables.
REQ-009 ENA/ENB input 1, port enables.
REQ-010 SSRA/SSRB input 1, synchronous output set/reset.
REQ-011 ADDRA/ADDRB input 11, word address 0..2047.
REQ-012 DIA/DIB input 8, write data; DIPA/DIPB input 1, write parity bit.
REQ-013 DOA/DOB output 8, registered read data; DOPA/DOPB output 1, registered parity.

Function
REQ-014 Storage SHALL be 2048 words x 9 bits, with {DIPx,DIx} as bit 8 and bits 7:0; initial contents all zero; reset does not alter contents.
REQ-015 All port actions SHALL occur on the rising edge of clock only when ENx=1; with ENx=0 there is no write and the outputs hold.
REQ-016 With ENx=1 and WEx=1, mem[ADDRx] SHALL be written with {DIPx,DIx} at the edge.
REQ-017 With ENx=1, WEx=0 and SSRx=0, {DOPx,DOx} SHALL equal mem[ADDRx] one cycle after the edge; read latency is 1 clock.
REQ-018 For a write with SSRx=0, output SHALL follow the mode: WRITE_FIRST gives the new data, READ_FIRST gives the prior contents, NO_CHANGE holds the previous output.
REQ-019 With ENx=1 and SSRx=1, the output SHALL load SRVAL_x; a write requested in the same cycle still updates memory.
REQ-020 A read on one port at the address the other port writes in the same edge SHALL return the old contents.
REQ-021 If both ports write the same address in the same edge, port A data SHALL be stored.
REQ-022 A collision is any same-address same-edge access where at least one port writes.
REQ-023 On a collision, WARNING_ONLY or ALL SHALL print a message naming the time and address.
REQ-024 On a collision, GENERATE_X_ONLY or ALL SHALL drive X on the output of each reading port that cycle and, for a write-write collision, store X.
REQ-025 With NONE, collisions SHALL be handled per REQ-020/021 and produce no message.
REQ-026 Ports A and B SHALL be fully symmetric, independent and simultaneously usable.

Reset
REQ-027 While reset=1, {DOPA,DOA} SHALL be INIT_A and {DOPB,DOB} SHALL be INIT_B, regardless of clock.
REQ-028 Reset SHALL take effect immediately; outputs hold their INIT values after deassertion until the next enabled edge.
REQ-029 Memory contents SHALL be unaffected by reset, including reset asserted mid-write; a write already clocked persists.

Verification
REQ-030 Port A writes 0x1A5 at address 5; port B reads address 5 on the next edge -> DOPB=1, DOB=0xA5 one cycle later.
REQ-031 READ_FIRST on A: mem[7]=0x012, then write 0x0FF at 7 with ENA=1 -> DOA=0x12 and a later read gives 0xFF; same test with WRITE_FIRST -> DOA=0xFF.
REQ-032 ENB=0 while address changes and A writes -> DOB holds; SSRB=1 with SRVAL_B=0x155 -> DOB=0x55, DOPB=1.
REQ-033 A writes 0x033 at address 2047 while B reads 2047 in the same edge, with NONE -> DOB is the old value and the next read gives 0x33; with ALL -> warning and DOB=X.
REQ-034 Assert reset mid-stream -> outputs go to INIT_A/INIT_B at once; after release, reading prior addresses returns the written data.

Source files
------------

// File: rtl/ramb16_s9_s9.sv
// ramb16_s9_s9: 2048x9 true dual-port RAM, one clock, per-port write modes and collision handling
module ramb16_s9_s9 #(
    parameter string      WRITE_MODE_A        = "WRITE_FIRST",
    parameter string      WRITE_MODE_B        = "WRITE_FIRST",
    parameter string      SIM_COLLISION_CHECK = "ALL",
    parameter logic [8:0] INIT_A              = 9'h000,
    parameter logic [8:0] INIT_B              = 9'h000,
    parameter logic [8:0] SRVAL_A             = 9'h000,
    parameter logic [8:0] SRVAL_B             = 9'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wea,
    input  logic        web,
    input  logic        ena,
    input  logic        enb,
    input  logic        ssra,
    input  logic        ssrb,
    input  logic [10:0] addra,
    input  logic [10:0] addrb,
    input  logic [7:0]  dia,
    input  logic [7:0]  dib,
    input  logic        dipa,
    input  logic        dipb,
    output logic [7:0]  doa,
    output logic [7:0]  dob,
    output logic        dopa,
    output logic        dopb
);
    localparam bit GEN_X = (SIM_COLLISION_CHECK == "GENERATE_X_ONLY") || (SIM_COLLISION_CHECK == "ALL");
    localparam bit WARN  = (SIM_COLLISION_CHECK == "WARNING_ONLY") || (SIM_COLLISION_CHECK == "ALL");
    localparam bit WF_A  = (WRITE_MODE_A == "WRITE_FIRST");
    localparam bit RF_A  = (WRITE_MODE_A == "READ_FIRST");
    localparam bit WF_B  = (WRITE_MODE_B == "WRITE_FIRST");
    localparam bit RF_B  = (WRITE_MODE_B == "READ_FIRST");

    logic [8:0] mem [2048];
    logic [8:0] rd_a, rd_b, din_a, din_b;
    logic [8:0] out_a_d, out_a_q, out_b_d, out_b_q;
    logic       wr_a, wr_b, coll, coll_ww;

    assign rd_a    = mem[addra];
    assign rd_b    = mem[addrb];
    assign din_a   = {dipa, dia};
    assign din_b   = {dipb, dib};
    assign wr_a    = ena && wea;
    assign wr_b    = enb && web;
    assign coll    = ena && enb && (addra == addrb) && (wea || web);
    assign coll_ww = coll && wea && web;

    assign {dopa, doa} = out_a_q;
    assign {dopb, dob} = out_b_q;

    // Next output per port: hold when disabled, SSR wins, then plain read or the write-mode choice
    always_comb begin
        out_a_d = !ena ? out_a_q : ssra ? SRVAL_A : !wea ? ((coll && GEN_X) ? 9'bx : rd_a) : WF_A ? din_a : RF_A ? rd_a : out_a_q;
        out_b_d = !enb ? out_b_q : ssrb ? SRVAL_B : !web ? ((coll && GEN_X) ? 9'bx : rd_b) : WF_B ? din_b : RF_B ? rd_b : out_b_q;
    end

    // Output registers; reset clears only these, never the array
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_a_q <= INIT_A;
            out_b_q <= INIT_B;
        end else begin
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
        end
    end

    // Array writes; port A wins a same-address double write, which is poisoned when X generation is on
    always_ff @(posedge clock) begin
        if (wr_b && !(wr_a && addra == addrb)) mem[addrb] <= din_b;
        if (wr_a) mem[addra] <= (coll_ww && GEN_X) ? 9'bx : din_a;
    end

    // Collision report for simulation
    always_ff @(posedge clock) begin
        if (WARN && coll) $warning("ramb16_s9_s9 collision at time %0t on address %0d", $time, addra);
    end
endmodule

// File: tb/tb_ramb16_s9_s9.sv
// tb_ramb16_s9_s9: directed and randomized checks of two differently configured RAM instances
module tb_ramb16_s9_s9;
    localparam logic [8:0] INIT_A1 = 9'h1C3, INIT_B1 = 9'h0A6, SRVAL_A1 = 9'h0F0, SRVAL_B1 = 9'h155;
    localparam logic [8:0] INIT_A2 = 9'h011, INIT_B2 = 9'h122, SRVAL_A2 = 9'h0AB, SRVAL_B2 = 9'h1CD;

    logic        clock = 0, reset = 0;
    logic        wea = 0, web = 0, ena = 0, enb = 0, ssra = 0, ssrb = 0;
    logic [10:0] addra = 0, addrb = 0;
    logic [7:0]  dia = 0, dib = 0;
    logic        dipa = 0, dipb = 0;
    logic [7:0]  doa1, dob1, doa2, dob2;
    logic        dopa1, dopb1, dopa2, dopb2;
    wire  [8:0]  oa1 = {dopa1, doa1}, ob1 = {dopb1, dob1}, oa2 = {dopa2, doa2}, ob2 = {dopb2, dob2};

    int n_checks = 0, n_fail = 0;

    logic [8:0] mem [2048];
    bit         known [2048];
    logic [8:0] ea1, eb1, ea2, eb2;
    bit         ka2, kb2;

    ramb16_s9_s9 #(
        .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE"), .SIM_COLLISION_CHECK("NONE"),
        .INIT_A(INIT_A1), .INIT_B(INIT_B1), .SRVAL_A(SRVAL_A1), .SRVAL_B(SRVAL_B1)
    ) u_dut1 (
        .clock(clock), .reset(reset), .wea(wea), .web(web), .ena(ena), .enb(enb), .ssra(ssra), .ssrb(ssrb),
        .addra(addra), .addrb(addrb), .dia(dia), .dib(dib), .dipa(dipa), .dipb(dipb),
        .doa(doa1), .dob(dob1), .dopa(dopa1), .dopb(dopb1)
    );

    ramb16_s9_s9 #(
        .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"), .SIM_COLLISION_CHECK("ALL"),
        .INIT_A(INIT_A2), .INIT_B(INIT_B2), .SRVAL_A(SRVAL_A2), .SRVAL_B(SRVAL_B2)
    ) u_dut2 (
        .clock(clock), .reset(reset), .wea(wea), .web(web), .ena(ena), .enb(enb), .ssra(ssra), .ssrb(ssrb),
        .addra(addra), .addrb(addrb), .dia(dia), .dib(dib), .dipa(dipa), .dipb(dipb),
        .doa(doa2), .dob(dob2), .dopa(dopa2), .dopb(dopb2)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] port_out(input string mode, input logic en, we, ssr,
                                            input logic [8:0] srval, din, old, hold);
        if (!en) return hold;
        if (ssr) return srval;
        if (!we || mode == "READ_FIRST") return old;
        return (mode == "WRITE_FIRST") ? din : hold;
    endfunction

    task automatic model_edge();
        logic [8:0] old_a, old_b, din_a, din_b;
        bit k_old_a, k_old_b, coll, ww;
        old_a = mem[addra]; old_b = mem[addrb];
        k_old_a = known[addra]; k_old_b = known[addrb];
        din_a = {dipa, dia}; din_b = {dipb, dib};
        coll = ena && enb && addra == addrb && (wea || web);
        ww = coll && wea && web;
        if (reset) begin
            ea1 = INIT_A1; eb1 = INIT_B1; ea2 = INIT_A2; eb2 = INIT_B2; ka2 = 1; kb2 = 1;
        end else begin
            ea1 = port_out("READ_FIRST", ena, wea, ssra, SRVAL_A1, din_a, old_a, ea1);
            eb1 = port_out("NO_CHANGE", enb, web, ssrb, SRVAL_B1, din_b, old_b, eb1);
            ea2 = port_out("WRITE_FIRST", ena, wea, ssra, SRVAL_A2, din_a, old_a, ea2);
            eb2 = port_out("WRITE_FIRST", enb, web, ssrb, SRVAL_B2, din_b, old_b, eb2);
            if (ena) ka2 = ssra || wea || (k_old_a && !coll);
            if (enb) kb2 = ssrb || web || (k_old_b && !coll);
        end
        if (enb && web) begin mem[addrb] = din_b; known[addrb] = 1; end
        if (ena && wea) begin mem[addra] = din_a; known[addra] = !ww; end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input logic en, we, ssr, input logic [10:0] addr, input logic [8:0] d);
        ena = en; wea = we; ssra = ssr; addra = addr; {dipa, dia} = d;
    endtask

    task automatic set_b(input logic en, we, ssr, input logic [10:0] addr, input logic [8:0] d);
        enb = en; web = we; ssrb = ssr; addrb = addr; {dipb, dib} = d;
    endtask

    task automatic test_reset();
        #2 reset = 1;
        #1;
        ea1 = INIT_A1; eb1 = INIT_B1; ea2 = INIT_A2; eb2 = INIT_B2; ka2 = 1; kb2 = 1;
        n_checks++; if (oa1 !== INIT_A1) begin n_fail++; $display("FAIL reset_a1 got %h want %h", oa1, INIT_A1); end
        n_checks++; if (ob1 !== INIT_B1) begin n_fail++; $display("FAIL reset_b1 got %h want %h", ob1, INIT_B1); end
        n_checks++; if (oa2 !== INIT_A2) begin n_fail++; $display("FAIL reset_a2 got %h want %h", oa2, INIT_A2); end
        n_checks++; if (ob2 !== INIT_B2) begin n_fail++; $display("FAIL reset_b2 got %h want %h", ob2, INIT_B2); end
        set_a(1, 0, 0, 11'd0, 9'h0); set_b(1, 0, 1, 11'd1, 9'h0);
        step();
        n_checks++; if (oa1 !== INIT_A1) begin n_fail++; $display("FAIL reset_clk_a1 got %h want %h", oa1, INIT_A1); end
        n_checks++; if (ob2 !== INIT_B2) begin n_fail++; $display("FAIL reset_clk_b2 got %h want %h", ob2, INIT_B2); end
        reset = 0;
        set_a(0, 0, 0, 11'd0, 9'h0); set_b(0, 0, 0, 11'd0, 9'h0);
    endtask

    task automatic test_write_read();
        set_a(1, 1, 0, 11'd5, 9'h1A5); set_b(0, 0, 0, 11'd0, 9'h0);
        step();
        n_checks++; if (oa2 !== 9'h1A5) begin n_fail++; $display("FAIL wf_write_a2 got %h want %h", oa2, 9'h1A5); end
        set_a(0, 0, 0, 11'd0, 9'h0); set_b(1, 0, 0, 11'd5, 9'h0);
        step();
        n_checks++; if (dopb1 !== 1'b1 || dob1 !== 8'hA5) begin n_fail++; $display("FAIL read_b1 got %b/%h want 1/a5", dopb1, dob1); end
        n_checks++; if (ob2 !== 9'h1A5) begin n_fail++; $display("FAIL read_b2 got %h want %h", ob2, 9'h1A5); end
    endtask

    task automatic test_write_modes();
        set_a(0, 0, 0, 11'd0, 9'h0); set_b(1, 1, 0, 11'd7, 9'h012);
        step();
        n_checks++; if (ob2 !== 9'h012) begin n_fail++; $display("FAIL wf_b2 got %h want %h", ob2, 9'h012); end
        set_b(0, 0, 0, 11'd0, 9'h0); set_a(1, 1, 0, 11'd7, 9'h0FF);
        step();
        n_checks++; if (oa1 !== 9'h012) begin n_fail++; $display("FAIL rf_a1 got %h want %h", oa1, 9'h012); end
        n_checks++; if (oa2 !== 9'h0FF) begin n_fail++; $display("FAIL wf_a2 got %h want %h", oa2, 9'h0FF); end
        set_a(1, 0, 0, 11'd7, 9'h0);
        step();
        n_checks++; if (oa1 !== 9'h0FF) begin n_fail++; $display("FAIL rf_reread_a1 got %h want %h", oa1, 9'h0FF); end
        n_checks++; if (oa2 !== 9'h0FF) begin n_fail++; $display("FAIL wf_reread_a2 got %h want %h", oa2, 9'h0FF); end
        set_a(0, 0, 0, 11'd0, 9'h0); set_b(1, 0, 0, 11'd7, 9'h0);
        step();
        set_b(1, 1, 0, 11'd8, 9'h1EE);
        step();
        n_checks++; if (ob1 !== 9'h0FF) begin n_fail++; $display("FAIL nc_hold_b1 got %h want %h", ob1, 9'h0FF); end
        n_checks++; if (ob2 !== 9'h1EE) begin n_fail++; $display("FAIL wf_b2_8 got %h want %h", ob2, 9'h1EE); end
    endtask

    task automatic test_enable_ssr();
        set_b(1, 0, 0, 11'd8, 9'h0);
        step();
        n_checks++; if (ob1 !== 9'h1EE) begin n_fail++; $display("FAIL read8_b1 got %h want %h", ob1, 9'h1EE); end
        for (int k = 0; k < 3; k++) begin
            set_a(1, 1, 0, 11'd8, 9'h03C + 9'(k)); set_b(0, 1, 1, 11'(20 + k), 9'(k));
            step();
            n_checks++; if (ob1 !== 9'h1EE) begin n_fail++; $display("FAIL en_hold_b1 k=%0d got %h want %h", k, ob1, 9'h1EE); end
            n_checks++; if (ob2 !== 9'h1EE) begin n_fail++; $display("FAIL en_hold_b2 k=%0d got %h want %h", k, ob2, 9'h1EE); end
        end
        set_a(0, 0, 0, 11'd0, 9'h0); set_b(1, 0, 1, 11'd8, 9'h0);
        step();
        n_checks++; if (dob1 !== 8'h55 || dopb1 !== 1'b1) begin n_fail++; $display("FAIL ssr_b1 got %b/%h want 1/55", dopb1, dob1); end
        n_checks++; if (ob2 !== SRVAL_B2) begin n_fail++; $display("FAIL ssr_b2 got %h want %h", ob2, SRVAL_B2); end
        set_b(1, 1, 1, 11'd9, 9'h077);
        step();
        n_checks++; if (ob2 !== SRVAL_B2) begin n_fail++; $display("FAIL ssr_wr_b2 got %h want %h", ob2, SRVAL_B2); end
        set_a(1, 0, 0, 11'd8, 9'h0); set_b(1, 0, 0, 11'd9, 9'h0);
        step();
        n_checks++; if (ob1 !== 9'h077) begin n_fail++; $display("FAIL ssr_mem_b1 got %h want %h", ob1, 9'h077); end
        n_checks++; if (ob2 !== 9'h077) begin n_fail++; $display("FAIL ssr_mem_b2 got %h want %h", ob2, 9'h077); end
        n_checks++; if (oa1 !== 9'h03E) begin n_fail++; $display("FAIL last_wr_a1 got %h want %h", oa1, 9'h03E); end
    endtask

    task automatic test_collision();
        set_a(1, 1, 0, 11'd2047, 9'h0C4); set_b(0, 0, 0, 11'd0, 9'h0);
        step();
        set_a(1, 1, 0, 11'd2047, 9'h033); set_b(1, 0, 0, 11'd2047, 9'h0);
        step();
        n_checks++; if (ob1 !== 9'h0C4) begin n_fail++; $display("FAIL coll_old_b1 got %h want %h", ob1, 9'h0C4); end
        set_a(0, 0, 0, 11'd0, 9'h0);
        step();
        n_checks++; if (ob1 !== 9'h033) begin n_fail++; $display("FAIL coll_new_b1 got %h want %h", ob1, 9'h033); end
        n_checks++; if (ob2 !== 9'h033) begin n_fail++; $display("FAIL coll_new_b2 got %h want %h", ob2, 9'h033); end
        set_a(1, 1, 0, 11'd100, 9'h111); set_b(1, 1, 0, 11'd100, 9'h0EE);
        step();
        set_a(1, 0, 0, 11'd100, 9'h0); set_b(0, 0, 0, 11'd0, 9'h0);
        step();
        n_checks++; if (oa1 !== 9'h111) begin n_fail++; $display("FAIL ww_a_wins got %h want %h", oa1, 9'h111); end
    endtask

    task automatic test_reset_mid();
        set_a(1, 1, 0, 11'd50, 9'h1EE); set_b(1, 0, 0, 11'd9, 9'h0);
        step();
        reset = 1;
        #1;
        ea1 = INIT_A1; eb1 = INIT_B1; ea2 = INIT_A2; eb2 = INIT_B2; ka2 = 1; kb2 = 1;
        n_checks++; if (oa1 !== INIT_A1) begin n_fail++; $display("FAIL mid_reset_a1 got %h want %h", oa1, INIT_A1); end
        n_checks++; if (ob1 !== INIT_B1) begin n_fail++; $display("FAIL mid_reset_b1 got %h want %h", ob1, INIT_B1); end
        n_checks++; if (oa2 !== INIT_A2) begin n_fail++; $display("FAIL mid_reset_a2 got %h want %h", oa2, INIT_A2); end
        n_checks++; if (ob2 !== INIT_B2) begin n_fail++; $display("FAIL mid_reset_b2 got %h want %h", ob2, INIT_B2); end
        set_a(0, 0, 0, 11'd0, 9'h0); set_b(0, 0, 0, 11'd0, 9'h0);
        step();
        reset = 0;
        step();
        n_checks++; if (oa1 !== INIT_A1) begin n_fail++; $display("FAIL post_reset_a1 got %h want %h", oa1, INIT_A1); end
        n_checks++; if (ob2 !== INIT_B2) begin n_fail++; $display("FAIL post_reset_b2 got %h want %h", ob2, INIT_B2); end
        set_a(1, 0, 0, 11'd50, 9'h0); set_b(1, 0, 0, 11'd5, 9'h0);
        step();
        n_checks++; if (oa1 !== 9'h1EE) begin n_fail++; $display("FAIL keep50_a1 got %h want %h", oa1, 9'h1EE); end
        n_checks++; if (ob1 !== 9'h1A5) begin n_fail++; $display("FAIL keep5_b1 got %h want %h", ob1, 9'h1A5); end
        n_checks++; if (oa2 !== 9'h1EE) begin n_fail++; $display("FAIL keep50_a2 got %h want %h", oa2, 9'h1EE); end
        n_checks++; if (ob2 !== 9'h1A5) begin n_fail++; $display("FAIL keep5_b2 got %h want %h", ob2, 9'h1A5); end
    endtask

    task automatic test_random();
        set_a(0, 0, 0, 11'd0, 9'h0);
        for (int i = 0; i < 16; i++) begin
            set_b(1, 1, 0, 11'(i), 9'($urandom));
            step();
        end
        set_b(0, 0, 0, 11'd0, 9'h0); set_a(1, 0, 0, 11'd0, 9'h0);
        step();
        for (int i = 0; i < 400; i++) begin
            set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 11'($urandom_range(0, 15)), 9'($urandom));
            set_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 11'($urandom_range(0, 15)), 9'($urandom));
            step();
            n_checks++; if (oa1 !== ea1) begin n_fail++; $display("FAIL rand_a1 cycle %0d got %h want %h", i, oa1, ea1); end
            n_checks++; if (ob1 !== eb1) begin n_fail++; $display("FAIL rand_b1 cycle %0d got %h want %h", i, ob1, eb1); end
            if (ka2) begin n_checks++; if (oa2 !== ea2) begin n_fail++; $display("FAIL rand_a2 cycle %0d got %h want %h", i, oa2, ea2); end end
            if (kb2) begin n_checks++; if (ob2 !== eb2) begin n_fail++; $display("FAIL rand_b2 cycle %0d got %h want %h", i, ob2, eb2); end end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin mem[i] = 9'h0; known[i] = 1; end
        ea1 = 0; eb1 = 0; ea2 = 0; eb2 = 0; ka2 = 1; kb2 = 1;
        test_reset();
        test_write_read();
        test_write_modes();
        test_enable_ssr();
        test_collision();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
